collatz_engine_p: RTL and testbench

- Parametrised successor to the 8-bit Collatz step counter.
- Computes the total stopping time (steps to reach 1) and the peak trajectory value for an N_W-bit start value.
- Supports a standard mode and a shortcut mode, with a start/busy/done handshake.
- Detects zero input, datapath overflow and step-counter saturation; sits behind the TT user-IO wrapper as the compute core.

---
 rtl/collatz_pkg.sv | 13 +
 rtl/collatz_step.sv | 37 +++
 rtl/collatz_engine_p.sv | 145 ++++++++++++++
 tb/tb_collatz_engine_p.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared state encoding and mode constants for the Collatz stopping-time engine.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_STD   = 1'b0;
    localparam logic MODE_SHORT = 1'b1;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step: halve an even value, or apply 3n+1
// (optionally halved) to an odd one, flagging results that do not fit ACC_W bits.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] value_i,
    input  logic             mode_i,
    output logic [ACC_W-1:0] next_o,
    output logic [ACC_W-1:0] oddProd_o,
    output logic             ovf_o
);

    logic [ACC_W+1:0] valueExt;
    logic [ACC_W+1:0] prod;
    logic             isOdd;

    // Two guard bits hold 3n+1 for any ACC_W-bit n without wrapping.
    assign valueExt  = {2'b00, value_i};
    assign prod      = (valueExt << 1) + valueExt + {{(ACC_W+1){1'b0}}, 1'b1};
    assign isOdd     = value_i[0];
    assign oddProd_o = prod[ACC_W-1:0];
    assign ovf_o     = isOdd && (prod[ACC_W+1:ACC_W] != 2'b00);

    always_comb begin
        next_o = {1'b0, value_i[ACC_W-1:1]};
        if (isOdd) begin
            if (mode_i == MODE_SHORT) begin
                next_o = prod[ACC_W:1];
            end else begin
                next_o = prod[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/collatz_engine_p.sv
// Collatz total-stopping-time engine: iterates one step per clock and reports
// step count, peak trajectory value and the condition that ended the run.
module collatz_engine_p
    import collatz_pkg::*;
#(
    parameter int N_W   = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N_W-1:0]   n_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps,
    output logic [ACC_W-1:0] peak,
    output logic             ovf,
    output logic             sat,
    output logic             err_zero
);

    localparam logic [N_W-1:0]   N_ONE   = N_W'(1);
    localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q,   state_d;
    logic             mode_q,    mode_d;
    logic [ACC_W-1:0] value_q,   value_d;
    logic [ACC_W-1:0] peak_q,    peak_d;
    logic [CNT_W-1:0] steps_q,   steps_d;
    logic             ovf_q,     ovf_d;
    logic             sat_q,     sat_d;
    logic             errZero_q, errZero_d;

    logic [ACC_W-1:0] stepNext;
    logic [ACC_W-1:0] stepOddProd;
    logic             stepOvf;
    logic [ACC_W-1:0] peakCand;
    logic [CNT_W-1:0] stepsInc;

    collatz_step #(
        .ACC_W (ACC_W)
    ) u_step (
        .value_i   (value_q),
        .mode_i    (mode_q),
        .next_o    (stepNext),
        .oddProd_o (stepOddProd),
        .ovf_o     (stepOvf)
    );

    // The peak sees the full 3n+1 even when shortcut mode stores its half.
    assign peakCand = value_q[0] ? stepOddProd : stepNext;
    assign stepsInc = steps_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_STD;
            value_q   <= '0;
            peak_q    <= '0;
            steps_q   <= '0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
            errZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            value_q   <= value_d;
            peak_q    <= peak_d;
            steps_q   <= steps_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
            errZero_q <= errZero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        value_d   = value_q;
        peak_d    = peak_q;
        steps_d   = steps_q;
        ovf_d     = ovf_q;
        sat_d     = sat_q;
        errZero_d = errZero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d    = mode;
                    value_d   = {{(ACC_W-N_W){1'b0}}, n_in};
                    peak_d    = {{(ACC_W-N_W){1'b0}}, n_in};
                    steps_d   = '0;
                    ovf_d     = 1'b0;
                    sat_d     = 1'b0;
                    errZero_d = 1'b0;
                    if (n_in == '0) begin
                        errZero_d = 1'b1;
                        state_d   = DONE;
                    end else if (n_in == N_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                // An overflowing step is discarded; the last good value stays visible.
                if (stepOvf) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    value_d = stepNext;
                    steps_d = stepsInc;
                    if (peakCand > peak_q) begin
                        peak_d = peakCand;
                    end
                    if (stepNext == ACC_ONE) begin
                        state_d = DONE;
                    end else if (stepsInc == CNT_MAX) begin
                        sat_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign steps    = steps_q;
    assign peak     = peak_q;
    assign ovf      = ovf_q;
    assign sat      = sat_q;
    assign err_zero = errZero_q;

endmodule

// File: tb/tb_collatz_engine_p.sv
// Directed bench for collatz_engine_p: default build plus narrow-accumulator
// and narrow-counter builds, with hand-computed stopping times and peaks.
module tb_collatz_engine_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [7:0] n_in;

    logic        start, busy, done, ovf, sat, err_zero;
    logic [7:0]  steps;
    logic [15:0] peak;

    logic        startO, busyO, doneO, ovfO, satO, errZeroO;
    logic [7:0]  stepsO;
    logic [11:0] peakO;

    logic        startS, busyS, doneS, ovfS, satS, errZeroS;
    logic [5:0]  stepsS;
    logic [15:0] peakS;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collatz_engine_p dut (
        .clk (clk), .rst (rst), .start (start), .mode (mode), .n_in (n_in),
        .busy (busy), .done (done), .steps (steps), .peak (peak),
        .ovf (ovf), .sat (sat), .err_zero (err_zero)
    );

    collatz_engine_p #(.N_W(8), .ACC_W(12), .CNT_W(8)) dutOvf (
        .clk (clk), .rst (rst), .start (startO), .mode (mode), .n_in (n_in),
        .busy (busyO), .done (doneO), .steps (stepsO), .peak (peakO),
        .ovf (ovfO), .sat (satO), .err_zero (errZeroO)
    );

    collatz_engine_p #(.N_W(8), .ACC_W(16), .CNT_W(6)) dutSat (
        .clk (clk), .rst (rst), .start (startS), .mode (mode), .n_in (n_in),
        .busy (busyS), .done (doneS), .steps (stepsS), .peak (peakS),
        .ovf (ovfS), .sat (satS), .err_zero (errZeroS)
    );

    function automatic logic doneSel(input int sel);
        case (sel)
            1:       return doneO;
            2:       return doneS;
            default: return done;
        endcase
    endfunction

    function automatic logic busySel(input int sel);
        case (sel)
            1:       return busyO;
            2:       return busyS;
            default: return busy;
        endcase
    endfunction

    // Pulses start on one instance; returns at the negedge after the start edge.
    task automatic applyStimulus(input int sel, input logic [7:0] nVal, input logic modeVal);
        @(negedge clk);
        n_in = nVal;
        mode = modeVal;
        case (sel)
            1:       startO = 1'b1;
            2:       startS = 1'b1;
            default: start  = 1'b1;
        endcase
        @(negedge clk);
        start  = 1'b0;
        startO = 1'b0;
        startS = 1'b0;
    endtask

    // Counts edges after the start edge until done, bounded by limit.
    task automatic waitDone(input int sel, input int limit, output int edges,
                            output int busyCnt, output int overlap);
        edges   = 0;
        busyCnt = 0;
        overlap = 0;
        while (!doneSel(sel) && edges < limit) begin
            if (busySel(sel)) busyCnt++;
            @(negedge clk);
            edges++;
            if (busySel(sel) && doneSel(sel)) overlap++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; startO = 1'b0; startS = 1'b0;
        mode = 1'b0; n_in = 8'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (steps !== 8'd0) begin failures++; $display("[TB] FAIL reset_steps: got %0d expected 0", steps); end
        checks++; if (peak !== 16'd0) begin failures++; $display("[TB] FAIL reset_peak: got %0d expected 0", peak); end
        checks++; if ({ovf, sat, err_zero} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {ovf, sat, err_zero}); end
        rst = 1'b0;
    endtask

    task automatic test_standard27();
        int edges, busyCnt, overlap;
        applyStimulus(0, 8'd27, 1'b0);
        waitDone(0, 200, edges, busyCnt, overlap);
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL n27_done: got %b expected 1", done); end
        checks++; if (edges !== 111) begin failures++; $display("[TB] FAIL n27_latency: got %0d expected 111", edges); end
        checks++; if (busyCnt !== 111) begin failures++; $display("[TB] FAIL n27_busy_cycles: got %0d expected 111", busyCnt); end
        checks++; if (overlap !== 0) begin failures++; $display("[TB] FAIL n27_busy_done_overlap: got %0d expected 0", overlap); end
        checks++; if (steps !== 8'd111) begin failures++; $display("[TB] FAIL n27_steps: got %0d expected 111", steps); end
        checks++; if (peak !== 16'd9232) begin failures++; $display("[TB] FAIL n27_peak: got %0d expected 9232", peak); end
        checks++; if ({ovf, sat, err_zero} !== 3'b000) begin failures++; $display("[TB] FAIL n27_flags: got %b expected 000", {ovf, sat, err_zero}); end
    endtask

    task automatic test_small_modes();
        int edges, busyCnt, overlap;
        applyStimulus(0, 8'd3, 1'b0);
        // A start while running (with a zero operand) must not disturb the run.
        n_in = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(0, 50, edges, busyCnt, overlap);
        checks++; if (edges + 1 !== 7) begin failures++; $display("[TB] FAIL n3std_latency: got %0d expected 7", edges + 1); end
        checks++; if (steps !== 8'd7) begin failures++; $display("[TB] FAIL n3std_steps: got %0d expected 7", steps); end
        checks++; if (peak !== 16'd16) begin failures++; $display("[TB] FAIL n3std_peak: got %0d expected 16", peak); end
        checks++; if (err_zero !== 1'b0) begin failures++; $display("[TB] FAIL n3std_start_in_run: got %b expected 0", err_zero); end
        applyStimulus(0, 8'd3, 1'b1);
        waitDone(0, 50, edges, busyCnt, overlap);
        checks++; if (edges !== 5) begin failures++; $display("[TB] FAIL n3short_latency: got %0d expected 5", edges); end
        checks++; if (steps !== 8'd5) begin failures++; $display("[TB] FAIL n3short_steps: got %0d expected 5", steps); end
        checks++; if (peak !== 16'd16) begin failures++; $display("[TB] FAIL n3short_peak: got %0d expected 16", peak); end
    endtask

    task automatic test_trivial();
        applyStimulus(0, 8'd1, 1'b0);
        checks++; if ({busy, done} !== 2'b01) begin failures++; $display("[TB] FAIL n1_done_next: got %b expected 01", {busy, done}); end
        checks++; if (steps !== 8'd0) begin failures++; $display("[TB] FAIL n1_steps: got %0d expected 0", steps); end
        checks++; if (peak !== 16'd1) begin failures++; $display("[TB] FAIL n1_peak: got %0d expected 1", peak); end
        checks++; if ({ovf, sat, err_zero} !== 3'b000) begin failures++; $display("[TB] FAIL n1_flags: got %b expected 000", {ovf, sat, err_zero}); end
        applyStimulus(0, 8'd0, 1'b0);
        checks++; if ({busy, done} !== 2'b01) begin failures++; $display("[TB] FAIL n0_done_next: got %b expected 01", {busy, done}); end
        checks++; if ({ovf, sat, err_zero} !== 3'b001) begin failures++; $display("[TB] FAIL n0_flags: got %b expected 001", {ovf, sat, err_zero}); end
        checks++; if (steps !== 8'd0) begin failures++; $display("[TB] FAIL n0_steps: got %0d expected 0", steps); end
        checks++; if (peak !== 16'd0) begin failures++; $display("[TB] FAIL n0_peak: got %0d expected 0", peak); end
    endtask

    task automatic test_overflow();
        int edges, busyCnt, overlap;
        // 27 first exceeds 4095 at 3*1619+1 = 4858, after 64 good steps.
        applyStimulus(1, 8'd27, 1'b0);
        waitDone(1, 200, edges, busyCnt, overlap);
        checks++; if (doneO !== 1'b1) begin failures++; $display("[TB] FAIL ovf_done: got %b expected 1", doneO); end
        checks++; if (edges !== 65) begin failures++; $display("[TB] FAIL ovf_latency: got %0d expected 65", edges); end
        checks++; if ({ovfO, satO, errZeroO} !== 3'b100) begin failures++; $display("[TB] FAIL ovf_flags: got %b expected 100", {ovfO, satO, errZeroO}); end
        checks++; if (stepsO !== 8'd64) begin failures++; $display("[TB] FAIL ovf_steps: got %0d expected 64", stepsO); end
        checks++; if (peakO !== 12'd3238) begin failures++; $display("[TB] FAIL ovf_peak: got %0d expected 3238", peakO); end
    endtask

    task automatic test_saturate();
        int edges, busyCnt, overlap;
        applyStimulus(2, 8'd27, 1'b0);
        waitDone(2, 200, edges, busyCnt, overlap);
        checks++; if (doneS !== 1'b1) begin failures++; $display("[TB] FAIL sat_done: got %b expected 1", doneS); end
        checks++; if (edges !== 63) begin failures++; $display("[TB] FAIL sat_latency: got %0d expected 63", edges); end
        checks++; if ({ovfS, satS, errZeroS} !== 3'b010) begin failures++; $display("[TB] FAIL sat_flags: got %b expected 010", {ovfS, satS, errZeroS}); end
        checks++; if (stepsS !== 6'd63) begin failures++; $display("[TB] FAIL sat_steps: got %0d expected 63", stepsS); end
        checks++; if (peakS !== 16'd3238) begin failures++; $display("[TB] FAIL sat_peak: got %0d expected 3238", peakS); end
    endtask

    task automatic test_back_to_back();
        int edges, busyCnt, overlap;
        applyStimulus(0, 8'd255, 1'b0);
        waitDone(0, 200, edges, busyCnt, overlap);
        checks++; if (steps !== 8'd47) begin failures++; $display("[TB] FAIL n255_steps: got %0d expected 47", steps); end
        checks++; if (peak !== 16'd13120) begin failures++; $display("[TB] FAIL n255_peak: got %0d expected 13120", peak); end
        repeat (3) @(negedge clk);
        checks++; if ({done, steps} !== {1'b1, 8'd47}) begin failures++; $display("[TB] FAIL done_hold: got done=%b steps=%0d expected done=1 steps=47", done, steps); end
        n_in = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin failures++; $display("[TB] FAIL restart_from_done: got %b expected 10", {busy, done}); end
        waitDone(0, 100, edges, busyCnt, overlap);
        checks++; if (edges !== 16) begin failures++; $display("[TB] FAIL n7_latency: got %0d expected 16", edges); end
        checks++; if (steps !== 8'd16) begin failures++; $display("[TB] FAIL n7_steps: got %0d expected 16", steps); end
        checks++; if (peak !== 16'd52) begin failures++; $display("[TB] FAIL n7_peak: got %0d expected 52", peak); end
    endtask

    task automatic test_reset_mid_run();
        int edges, busyCnt, overlap;
        applyStimulus(0, 8'd27, 1'b0);
        repeat (50) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrun_busy: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done, ovf, sat, err_zero} !== 5'b00000) begin failures++; $display("[TB] FAIL midrun_reset_ctrl: got %b expected 00000", {busy, done, ovf, sat, err_zero}); end
        checks++; if ({steps, peak} !== 24'd0) begin failures++; $display("[TB] FAIL midrun_reset_data: got steps=%0d peak=%0d expected 0 0", steps, peak); end
        rst = 1'b0;
        applyStimulus(0, 8'd7, 1'b0);
        waitDone(0, 100, edges, busyCnt, overlap);
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL after_reset_done: got %b expected 1", done); end
        checks++; if (steps !== 8'd16) begin failures++; $display("[TB] FAIL after_reset_steps: got %0d expected 16", steps); end
        checks++; if (peak !== 16'd52) begin failures++; $display("[TB] FAIL after_reset_peak: got %0d expected 52", peak); end
    endtask

    initial begin
        test_reset();
        test_standard27();
        test_small_modes();
        test_trivial();
        test_overflow();
        test_saturate();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
